// File: rtl/ai_cache_sa.sv
// N-way set-associative write-back/write-allocate cache, one word per line, round-robin victims.
// Define AI_CACHE_STATS_EN to add saturating hit/miss/writeback counters (stat_* ports).
module ai_cache_sa #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int NUM_SETS   = 256,
  parameter int NUM_WAYS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_rdata
`ifdef AI_CACHE_STATS_EN
  ,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses,
  output logic [31:0]           stat_evicts
`endif
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_EVICT, S_FILL_REQ, S_FILL_WAIT, S_RESP
  } state_t;

  state_t state_q, state_d;

  logic [NUM_SETS-1:0][NUM_WAYS-1:0] valid_q;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0] dirty_q;
  logic [NUM_SETS-1:0][WAY_W-1:0]    rr_q;
  logic [TAG_W-1:0]                  tag_q  [NUM_SETS][NUM_WAYS];
  logic [DATA_WIDTH-1:0]             data_q [NUM_SETS][NUM_WAYS];

  logic                  req_write_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;
  logic [WAY_W-1:0]      way_q, way_d;
  logic                  rsp_hit_q, rsp_hit_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit, inv_found, victim_dirty;
  logic [WAY_W-1:0]      hit_way, inv_way, victim_way, rr_next;
  logic                  accept, rr_adv, wr_en, wr_dirty;
  logic [DATA_WIDTH-1:0] wr_data;

  assign idx = req_addr_q[IDX_W-1:0];
  assign tag = req_addr_q[ADDR_WIDTH-1:IDX_W];

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  // Invalid ways are always preferred; the round-robin pointer only moves when a valid line is displaced.
  assign victim_way   = inv_found ? inv_way : rr_q[idx];
  assign victim_dirty = valid_q[idx][victim_way] & dirty_q[idx][victim_way];
  assign rr_next      = (rr_q[idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q[idx] + 1'b1;

  always_comb begin
    state_d       = state_q;
    way_d         = way_q;
    rsp_hit_d     = rsp_hit_q;
    rsp_rdata_d   = rsp_rdata_q;
    req_ready     = 1'b0;
    accept        = 1'b0;
    rr_adv        = 1'b0;
    wr_en         = 1'b0;
    wr_dirty      = 1'b0;
    wr_data       = req_wdata_q;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = ~reset;
        if (req_valid) begin
          accept  = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit) begin
          way_d     = hit_way;
          rsp_hit_d = 1'b1;
          if (req_write_q) begin
            wr_en       = 1'b1;
            wr_dirty    = 1'b1;
            rsp_rdata_d = req_wdata_q;
          end else begin
            rsp_rdata_d = data_q[idx][hit_way];
          end
          state_d = S_RESP;
        end else begin
          way_d  = victim_way;
          rr_adv = ~inv_found;
          if (victim_dirty) begin
            state_d = S_EVICT;
          end else if (req_write_q) begin
            wr_en       = 1'b1;
            wr_dirty    = 1'b1;
            rsp_hit_d   = 1'b0;
            rsp_rdata_d = req_wdata_q;
            state_d     = S_RESP;
          end else begin
            state_d = S_FILL_REQ;
          end
        end
      end
      S_EVICT: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {tag_q[idx][way_q], idx};
        mem_req_wdata = data_q[idx][way_q];
        if (mem_req_ready) begin
          if (req_write_q) begin
            wr_en       = 1'b1;
            wr_dirty    = 1'b1;
            rsp_hit_d   = 1'b0;
            rsp_rdata_d = req_wdata_q;
            state_d     = S_RESP;
          end else begin
            state_d = S_FILL_REQ;
          end
        end
      end
      S_FILL_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = req_addr_q;
        if (mem_req_ready) state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (mem_rsp_valid) begin
          wr_en       = 1'b1;
          wr_data     = mem_rsp_rdata;
          rsp_hit_d   = 1'b0;
          rsp_rdata_d = mem_rsp_rdata;
          state_d     = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Control state: reset aborts any transaction and discards dirty lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      rr_q        <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (wr_en) begin
        valid_q[idx][way_d] <= 1'b1;
        dirty_q[idx][way_d] <= wr_dirty;
      end
      if (rr_adv) rr_q[idx] <= rr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_write_q <= req_write;
      req_addr_q  <= req_addr;
      req_wdata_q <= req_wdata;
    end
    way_q <= way_d;
    if (wr_en) begin
      tag_q[idx][way_d]  <= tag;
      data_q[idx][way_d] <= wr_data;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_hit   = rsp_hit_q;
  assign rsp_rdata = rsp_rdata_q;

`ifdef AI_CACHE_STATS_EN
  logic [31:0] hits_q, misses_q, evicts_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      hits_q   <= '0;
      misses_q <= '0;
      evicts_q <= '0;
    end else begin
      if (state_q == S_LOOKUP && hit)           hits_q   <= sat_inc(hits_q);
      if (state_q == S_LOOKUP && !hit)          misses_q <= sat_inc(misses_q);
      if (state_q == S_EVICT && mem_req_ready)  evicts_q <= sat_inc(evicts_q);
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_evicts = evicts_q;
`endif

endmodule

// File: tb/tb_ai_cache_sa.sv
// Self-checking bench for ai_cache_sa (4 sets, 2 ways): directed scenarios plus random traffic
// against a line-level cache model and a backing-memory model with random handshake timing.
`timescale 1ns/1ps
module tb_ai_cache_sa;
  localparam int AW = 32;
  localparam int DW = 128;
  localparam int NS = 4;
  localparam int NW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_hit;
  logic [DW-1:0] rsp_rdata;
  logic          mem_req_valid, mem_req_ready, mem_req_write;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_rdata;
`ifdef AI_CACHE_STATS_EN
  logic [31:0]   stat_hits, stat_misses, stat_evicts;
`endif

  always #5 clk = ~clk;

  ai_cache_sa #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_rdata(rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_write(mem_req_write),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
`ifdef AI_CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_evicts(stat_evicts)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Backing memory: unwritten words read as an address-derived pattern.
  logic [DW-1:0] mem [logic [31:0]];

  function automatic logic [DW-1:0] mem_peek(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a, ~a, a ^ 32'h5A5A_5A5A, 32'hC0DE_0000 + a};
  endfunction

  // Cache model: each set holds up to NW lines identified by full word address.
  bit            m_v    [NS][NW];
  bit            m_d    [NS][NW];
  logic [31:0]   m_a    [NS][NW];
  logic [DW-1:0] m_data [NS][NW];
  int            m_rr   [NS];

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NW; w++) begin
        m_v[s][w] = 1'b0;
        m_d[s][w] = 1'b0;
      end
    end
  endtask

  task automatic model_access(input bit wr, input logic [31:0] a, input logic [DW-1:0] wd,
                              output bit hit, output logic [DW-1:0] rd, output bit wb,
                              output logic [31:0] wba, output logic [DW-1:0] wbd, output bit fill);
    int s;
    int v;
    s = int'(a % NS);
    hit = 1'b0; rd = '0; wb = 1'b0; wba = '0; wbd = '0; fill = 1'b0; v = -1;
    for (int w = 0; w < NW; w++)
      if (m_v[s][w] && m_a[s][w] == a) begin hit = 1'b1; v = w; end
    if (hit) begin
      if (wr) begin m_data[s][v] = wd; m_d[s][v] = 1'b1; rd = wd; end
      else rd = m_data[s][v];
      return;
    end
    for (int w = NW - 1; w >= 0; w--)
      if (!m_v[s][w]) v = w;
    if (v < 0) begin
      v = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % NW;
    end
    if (m_v[s][v] && m_d[s][v]) begin wb = 1'b1; wba = m_a[s][v]; wbd = m_data[s][v]; end
    m_v[s][v] = 1'b1;
    m_a[s][v] = a;
    if (wr) begin m_d[s][v] = 1'b1; m_data[s][v] = wd; rd = wd; end
    else begin fill = 1'b1; rd = mem_peek(a); m_d[s][v] = 1'b0; m_data[s][v] = rd; end
  endtask

  // Memory fabric responder and traffic log.
  logic [31:0]   wb_addr_q[$];
  logic [DW-1:0] wb_data_q[$];
  logic [31:0]   fill_q[$];
  bit            ready_rand = 1'b0;
  bit            late_mode  = 1'b0;
  bit            spur_en    = 1'b0;
  int            hold_left  = 0;
  bit            snap_set   = 1'b0;
  logic [31:0]   snap_addr;
  logic [DW-1:0] snap_data;
  logic          snap_wr;
  bit            fill_busy  = 1'b0;
  int            fill_wait  = 0;
  logic [31:0]   fill_addr  = '0;

  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rsp_valid = 1'b0;
      mem_rsp_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (fill_busy) begin
        if (fill_wait == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = mem_peek(fill_addr);
          fill_busy = 1'b0;
        end else begin
          fill_wait--;
        end
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        mem_rsp_valid = 1'b1;
      end
      if (mem_req_valid) begin
        if (hold_left > 0) begin
          if (!snap_set) begin
            snap_set = 1'b1; snap_addr = mem_req_addr; snap_data = mem_req_wdata; snap_wr = mem_req_write;
          end else begin
            chk("hold.addr", mem_req_addr, snap_addr);
            chk("hold.wdata", mem_req_wdata, snap_data);
            chk("hold.write", mem_req_write, snap_wr);
          end
          chk("hold.rsp_valid", rsp_valid, 0);
          chk("hold.req_ready", req_ready, 0);
          hold_left--;
          mem_req_ready = 1'b0;
        end else begin
          mem_req_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (mem_req_ready) begin
          if (mem_req_write) begin
            wb_addr_q.push_back(mem_req_addr);
            wb_data_q.push_back(mem_req_wdata);
            mem[mem_req_addr] = mem_req_wdata;
          end else begin
            fill_q.push_back(mem_req_addr);
            fill_busy = 1'b1;
            fill_addr = mem_req_addr;
            fill_wait = late_mode ? 8 : $urandom_range(0, 3);
          end
        end
      end else begin
        mem_req_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Results of the most recent transaction, for the directed literal checks.
  int            last_lat;
  int            last_wb_n, last_fill_n;
  logic [31:0]   last_wb_addr;
  logic [DW-1:0] last_wb_data;

  task automatic do_req(input string tn, input bit wr, input logic [31:0] a, input logic [DW-1:0] wd);
    bit            eh, ewb, ef;
    logic [DW-1:0] erd, ewbd;
    logic [31:0]   ewba;
    int            cnt;
    model_access(wr, a, wd, eh, erd, ewb, ewba, ewbd, ef);
    wb_addr_q.delete(); wb_data_q.delete(); fill_q.delete();
    chk({tn, ".req_ready_idle"}, req_ready, 1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
    req_wdata = {$urandom, $urandom, $urandom, $urandom};
    cnt = 1;
    while (!rsp_valid && cnt < 200) begin
      chk({tn, ".req_ready_busy"}, req_ready, 0);
      @(negedge clk);
      cnt++;
    end
    chk({tn, ".rsp_valid"}, rsp_valid, 1);
    chk({tn, ".rsp_hit"}, rsp_hit, eh);
    chk({tn, ".rsp_rdata"}, rsp_rdata, erd);
    if (!ewb && !ef) chk({tn, ".latency"}, cnt, 2);
    else             chk({tn, ".latency_ge3"}, (cnt >= 3), 1);
    last_lat = cnt; last_wb_n = wb_addr_q.size(); last_fill_n = fill_q.size();
    last_wb_addr = '0; last_wb_data = '0;
    chk({tn, ".wb_count"}, last_wb_n, ewb);
    if (ewb && last_wb_n > 0) begin
      last_wb_addr = wb_addr_q[0]; last_wb_data = wb_data_q[0];
      chk({tn, ".wb_addr"}, last_wb_addr, ewba);
      chk({tn, ".wb_data"}, last_wb_data, ewbd);
    end
    chk({tn, ".fill_count"}, last_fill_n, ef);
    if (ef && last_fill_n > 0) chk({tn, ".fill_addr"}, fill_q[0], a);
    @(negedge clk);
    chk({tn, ".rsp_pulse"}, rsp_valid, 0);
    chk({tn, ".rsp_hit_held"}, rsp_hit, eh);
    chk({tn, ".rsp_rdata_held"}, rsp_rdata, erd);
  endtask

  initial begin
    bit            eh, ewb, ef;
    logic [DW-1:0] erd, ewbd;
    logic [31:0]   ewba, a;
    int            cnt;

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    model_reset();
    mem[32'h10] = 128'hA5;
    repeat (3) @(negedge clk);
    chk("reset.req_ready", req_ready, 0);
    chk("reset.rsp_valid", rsp_valid, 0);
    chk("reset.rsp_hit", rsp_hit, 0);
    chk("reset.rsp_rdata", rsp_rdata, 0);
    chk("reset.mem_req_valid", mem_req_valid, 0);
    reset = 1'b0;
    @(negedge clk);

    // Cold read then re-read hit.
    do_req("t1.cold", 0, 32'h10, '0);
    chk("t1.cold_hit", rsp_hit, 0);
    chk("t1.cold_data", rsp_rdata, 128'hA5);
    chk("t1.cold_fill", last_fill_n, 1);
    do_req("t1.hit", 0, 32'h10, '0);
    chk("t1.hit_hit", rsp_hit, 1);
    chk("t1.hit_data", rsp_rdata, 128'hA5);
    chk("t1.hit_lat", last_lat, 2);
    chk("t1.hit_nomem", last_fill_n + last_wb_n, 0);

    // Fill set 0 with dirty writes, then force a dirty eviction.
    do_req("t2.w20", 1, 32'h20, 128'h11);
    chk("t2.w20_hit", rsp_hit, 0);
    do_req("t2.w30", 1, 32'h30, 128'h22);
    chk("t2.w30_hit", rsp_hit, 0);
    chk("t2.w30_nomem", last_fill_n + last_wb_n, 0);
    do_req("t2.w40", 1, 32'h40, 128'h33);
    chk("t2.w40_hit", rsp_hit, 0);
    chk("t2.wb_addr_lit", last_wb_addr, 32'h20);
    chk("t2.wb_data_lit", last_wb_data, 128'h11);
`ifdef AI_CACHE_STATS_EN
    chk("t6.stat_hits", stat_hits, 1);
    chk("t6.stat_misses", stat_misses, 4);
    chk("t6.stat_evicts", stat_evicts, 1);
`endif

    // Hit on 0x30, write-hit it, then evict it.
    do_req("t3.r30", 0, 32'h30, '0);
    chk("t3.r30_hit", rsp_hit, 1);
    chk("t3.r30_data", rsp_rdata, 128'h22);
    do_req("t3.w30", 1, 32'h30, 128'h44);
    chk("t3.w30_hit", rsp_hit, 1);
    do_req("t3.w50", 1, 32'h50, 128'h55);
    chk("t3.wb_addr_lit", last_wb_addr, 32'h30);
    chk("t3.wb_data_lit", last_wb_data, 128'h44);

    // Writeback held off for 5 cycles.
    hold_left = 5; snap_set = 1'b0;
    do_req("t4.r60", 0, 32'h60, '0);
    chk("t4.hold_done", hold_left, 0);
    chk("t4.wb_addr_lit", last_wb_addr, 32'h40);
    chk("t4.wb_data_lit", last_wb_data, 128'h33);

    // Reset while waiting for fill data; the late response must be ignored.
    model_access(0, 32'h70, '0, eh, erd, ewb, ewba, ewbd, ef);
    wb_addr_q.delete(); wb_data_q.delete(); fill_q.delete();
    late_mode = 1'b1;
    chk("t5.req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h70;
    @(negedge clk);
    req_valid = 1'b0;
    cnt = 0;
    while (fill_q.size() == 0 && cnt < 100) begin @(negedge clk); cnt++; end
    chk("t5.fill_seen", (fill_q.size() > 0), 1);
    chk("t5.wb_count", wb_addr_q.size(), ewb);
    if (wb_addr_q.size() > 0) begin
      chk("t5.wb_addr", wb_addr_q[0], 32'h50);
      chk("t5.wb_data", wb_data_q[0], 128'h55);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5.mem_req_valid", mem_req_valid, 0);
    chk("t5.rsp_valid", rsp_valid, 0);
    chk("t5.req_ready_rst", req_ready, 0);
    chk("t5.rsp_rdata_rst", rsp_rdata, 0);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t5.late_rsp_valid", rsp_valid, 0);
      chk("t5.late_mem_req", mem_req_valid, 0);
    end
    late_mode = 1'b0;
    do_req("t5.r60", 0, 32'h60, '0);
    chk("t5.r60_miss", rsp_hit, 0);

    // Random traffic with random memory timing and spurious fill pulses.
    ready_rand = 1'b1;
    spur_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      a = $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) a = a | 32'hFFFF_FF00;
      do_req("rnd", 1'($urandom_range(0, 1)), a, {$urandom, $urandom, $urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
